// File: rtl/apb4_mst.sv
`default_nettype none
// ============================================================================
// Module   : apb4_mst
// Brief    : APB4 initiator turning a valid/ready request/response handshake
//            into APB4 SETUP/ACCESS transfers, one transfer outstanding.
//            Optional ACCESS watchdog enabled by APB4_MST_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module apb4_mst #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_write_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_strb_i,
    input  logic [2:0]              req_prot_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [DATA_WIDTH-1:0]   resp_rdata_o,
    output logic                    resp_err_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [2:0]              pprot_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    input  logic                    pready_i,
    input  logic                    pslverr_i
);

    localparam int         c_strb_w    = DATA_WIDTH / 8;
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_setup  = 2'd1;
    localparam logic [1:0] c_st_access = 2'd2;
    localparam logic [1:0] c_st_resp   = 2'd3;

    if (((DATA_WIDTH % 8) != 0) || (TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 65535)) begin : g_param_check
        $error("apb4_mst: illegal DATA_WIDTH or TIMEOUT_CYC");
    end

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  w_accept;
    logic                  w_timeout;

    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [2:0]            r_pprot;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [c_strb_w-1:0]   r_pstrb;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    assign w_accept = req_valid_i & req_ready_o;

`ifdef APB4_MST_TIMEOUT_EN
    // Abort on the ACCESS cycle whose stall would bring the count to TIMEOUT_CYC.
    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYC - 1);

    logic [15:0] r_wait_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wait_cnt <= '0;
        end else if (w_accept) begin
            r_wait_cnt <= '0;
        end else if ((r_state == c_st_access) && !pready_i && (r_wait_cnt != 16'hFFFF)) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

    assign w_timeout = (r_state == c_st_access) & ~pready_i & (r_wait_cnt >= c_timeout_last);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) w_state_nxt = c_st_setup;
            end
            c_st_setup: begin
                w_state_nxt = c_st_access;
            end
            c_st_access: begin
                if (pready_i || w_timeout) w_state_nxt = c_st_resp;
            end
            c_st_resp: begin
                if (resp_ready_i) w_state_nxt = req_valid_i ? c_st_setup : c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_comb begin
        psel_o       = 1'b0;
        penable_o    = 1'b0;
        resp_valid_o = 1'b0;
        req_ready_o  = 1'b0;
        case (r_state)
            c_st_idle: begin
                req_ready_o = 1'b1;
            end
            c_st_setup: begin
                psel_o = 1'b1;
            end
            c_st_access: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
            end
            c_st_resp: begin
                resp_valid_o = 1'b1;
                req_ready_o  = resp_ready_i;
            end
            default: begin
                req_ready_o = 1'b0;
            end
        endcase
    end

    // Request fields only load on acceptance, so they hold through RESP and IDLE.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_paddr  <= '0;
            r_pprot  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
        end else if (w_accept) begin
            r_paddr  <= req_addr_i;
            r_pprot  <= req_prot_i;
            r_pwrite <= req_write_i;
            r_pwdata <= req_wdata_i;
            r_pstrb  <= req_write_i ? req_strb_i : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (r_state == c_st_access) begin
            if (pready_i) begin
                r_rdata <= r_pwrite ? '0 : prdata_i;
                r_err   <= pslverr_i;
            end else if (w_timeout) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

    assign paddr_o      = r_paddr;
    assign pprot_o      = r_pprot;
    assign pwrite_o     = r_pwrite;
    assign pwdata_o     = r_pwdata;
    assign pstrb_o      = r_pstrb;
    assign resp_rdata_o = r_rdata;
    assign resp_err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_apb4_mst.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb4_mst
// Brief    : Randomised self-checking bench for apb4_mst against a
//            transaction-level timeline model and a scripted APB slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb4_mst;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;   // ACCESS stall cycles before pready; -1 = never
        logic [31:0] srdata;
        bit          serr;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic          req_write = 1'b0;
    logic [DW-1:0] req_wdata = '0;
    logic [SW-1:0] req_strb = '0;
    logic [2:0]    req_prot = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic [AW-1:0] paddr;
    logic [2:0]    pprot;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;

    txn_t drv_t;
    txn_t cur;
    txn_t last;
    txn_t slv_q[$];
    int   acc_cyc_q[$];
    bit   active = 1'b0;
    int   k = 0;
    int   cyc = 0;
    bit   rr_force = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    apb4_mst #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .TIMEOUT_CYC (TO)
    ) u_dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_write_i  (req_write),
        .req_wdata_i  (req_wdata),
        .req_strb_i   (req_strb),
        .req_prot_i   (req_prot),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .paddr_o      (paddr),
        .pprot_o      (pprot),
        .psel_o       (psel),
        .penable_o    (penable),
        .pwrite_o     (pwrite),
        .pwdata_o     (pwdata),
        .pstrb_o      (pstrb),
        .prdata_i     (prdata),
        .pready_i     (pready),
        .pslverr_i    (pslverr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    function automatic txn_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input logic [2:0] prot, input int waits,
                                input logic [31:0] srdata, input bit serr);
        txn_t t;
        t.wr = wr; t.addr = addr; t.wdata = wdata; t.strb = strb; t.prot = prot;
        t.waits = waits; t.srdata = srdata; t.serr = serr;
        return t;
    endfunction

    // Length of the ACCESS stall the master will actually see, and whether it aborts.
    function automatic void access_len(input txn_t t, output int w, output bit ab);
        w  = t.waits;
        ab = 1'b0;
`ifdef APB4_MST_TIMEOUT_EN
        if ((t.waits < 0) || (t.waits >= TO)) begin
            w  = TO - 1;
            ab = 1'b1;
        end
`endif
    endfunction

    task automatic check_outputs();
        int w;
        bit ab;
        bit in_resp;
        w = 0;
        ab = 1'b0;
        if (active) access_len(cur, w, ab);
        in_resp = active && (k >= w + 2);
        check_eq("psel", 32'(psel), 32'(active && (k <= w + 1)));
        check_eq("penable", 32'(penable), 32'(active && (k >= 1) && (k <= w + 1)));
        check_eq("resp_valid", 32'(resp_valid), 32'(in_resp));
        check_eq("req_ready", 32'(req_ready), 32'(!active || (in_resp && resp_ready)));
        check_eq("paddr", paddr, last.addr);
        check_eq("pwrite", 32'(pwrite), 32'(last.wr));
        check_eq("pwdata", pwdata, last.wdata);
        check_eq("pstrb", 32'(pstrb), last.wr ? 32'(last.strb) : 32'd0);
        check_eq("pprot", 32'(pprot), 32'(last.prot));
        if (in_resp) begin
            check_eq("resp_rdata", resp_rdata, (ab || cur.wr) ? 32'd0 : cur.srdata);
            check_eq("resp_err", 32'(resp_err), ab ? 32'd1 : 32'(cur.serr));
        end
    endtask

    // Timeline model: k counts edges since acceptance; SETUP at k=0, ACCESS for w+1 cycles, then RESP.
    initial begin
        txn_t cap;
        bit   acc;
        bit   done;
        last = mk(1'b0, '0, '0, '0, '0, 0, '0, 1'b0);
        cur  = last;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                active = 1'b0;
                k = 0;
                last = mk(1'b0, '0, '0, '0, '0, 0, '0, 1'b0);
                slv_q.delete();
                continue;
            end
            acc  = req_valid && req_ready;
            done = resp_valid && resp_ready;
            cap  = drv_t;
            cap.wr = req_write; cap.addr = req_addr; cap.wdata = req_wdata;
            cap.strb = req_strb; cap.prot = req_prot;
            cyc++;
            #1;
            if (active) k++;
            if (done) active = 1'b0;
            if (acc) begin
                active = 1'b1;
                k = 0;
                cur = cap;
                last = cap;
                slv_q.push_back(cap);
                acc_cyc_q.push_back(cyc);
            end
            if (rst_n) check_outputs();
        end
    end

    // Scripted slave: noise outside ACCESS, pready after the transaction's wait count.
    initial begin
        txn_t scur;
        int   acc_cnt;
        acc_cnt = 0;
        scur = mk(1'b0, '0, '0, '0, '0, -1, '0, 1'b0);
        forever begin
            @(negedge clk);
            if (psel && penable) begin
                if (acc_cnt == 0) begin
                    check_eq("slave_q_nonempty", 32'(slv_q.size() != 0), 32'd1);
                    if (slv_q.size() != 0) scur = slv_q.pop_front();
                end
                if ((scur.waits >= 0) && (acc_cnt == scur.waits)) begin
                    pready  = 1'b1;
                    prdata  = scur.srdata;
                    pslverr = scur.serr;
                end else begin
                    pready  = 1'b0;
                    prdata  = $urandom;
                    pslverr = 1'($urandom);
                end
                acc_cnt++;
            end else begin
                acc_cnt = 0;
                pready  = 1'($urandom);
                prdata  = $urandom;
                pslverr = 1'($urandom);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            resp_ready = rr_force ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input txn_t t);
        bit got;
        int n;
        @(negedge clk);
        drv_t     = t;
        req_valid = 1'b1;
        req_write = t.wr;
        req_addr  = t.addr;
        req_wdata = t.wdata;
        req_strb  = t.strb;
        req_prot  = t.prot;
        got = 1'b0;
        n = 0;
        while (!got && (n < 100)) begin
            @(posedge clk);
            got = req_ready;
            n++;
        end
        if (!got) begin
            check_eq("accept_timeout", 32'(got), 32'd1);
            req_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        int sz;
        txn_t t;
        drv_t = mk(1'b0, '0, '0, '0, '0, 0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_psel", 32'(psel), 32'd0);
        check_eq("rst_penable", 32'(penable), 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_paddr", paddr, 32'd0);
        check_eq("rst_pwdata", pwdata, 32'd0);
        check_eq("rst_resp_rdata", resp_rdata, 32'd0);
        check_eq("rst_resp_err", 32'(resp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(mk(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0, 32'h0, 1'b0));
        idle(4);
        issue(mk(1'b0, 32'h04, 32'hA5A5A5A5, 4'hF, 3'd2, 3, 32'h12345678, 1'b0));
        idle(6);
        issue(mk(1'b1, 32'h20, 32'hCAFEF00D, 4'h3, 3'd1, 1, 32'h55555555, 1'b1));
        idle(6);

        rr_force = 1'b1;
        for (int i = 0; i < 4; i++)
            issue(mk(1'(i), 32'h100 + 32'(i * 4), $urandom, 4'hF, 3'd0, 0, $urandom, 1'b0));
        idle(6);
        sz = acc_cyc_q.size();
        for (int i = 1; i <= 3; i++)
            check_eq("b2b_pitch", 32'(acc_cyc_q[sz - i] - acc_cyc_q[sz - i - 1]), 32'd3);
        rr_force = 1'b0;

`ifdef APB4_MST_TIMEOUT_EN
        issue(mk(1'b0, 32'h40, 32'h0, 4'hF, 3'd0, -1, 32'hBAD0BAD0, 1'b0));
        idle(TO + 6);
`endif
        issue(mk(1'b0, 32'h44, 32'h0, 4'hF, 3'd0, TO - 1, 32'h0BADF00D, 1'b0));
        idle(TO + 6);

        issue(mk(1'b0, 32'h80, 32'h11111111, 4'hF, 3'd7, 6, 32'h22222222, 1'b0));
        repeat (3) @(posedge clk);
        #3;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("arst_psel", 32'(psel), 32'd0);
        check_eq("arst_penable", 32'(penable), 32'd0);
        check_eq("arst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("arst_req_ready", 32'(req_ready), 32'd1);
        check_eq("arst_paddr", paddr, 32'd0);
        check_eq("arst_pprot", 32'(pprot), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            t = mk(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
                   int'($urandom_range(0, 4)), $urandom, ($urandom_range(0, 3) == 0));
            issue(t);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 3)));
        end
        idle(1);
        for (int i = 0; (i < 200) && active; i++) @(posedge clk);
        check_eq("drain_idle", 32'(active), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
